// File: rtl/axi4_subordinate_mem.sv
// AXI4-lite style subordinate memory with independent write/read paths
// and per-path wait states; single-beat word accesses only.
module axi4_subordinate_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int WR_WAIT   = 0,
    parameter int RD_WAIT   = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [2:0]  i_awprot,
    input  logic [31:0] i_wdata,
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic        i_wlast,
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic [1:0]  o_bresp,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    input  logic [2:0]  i_arprot,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [1:0]  o_rresp
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {WIDLE, WWAIT, WRESP} wstate_t;
    typedef enum logic [1:0] {RIDLE, RWAIT, RDATA} rstate_t;

    logic [31:0] r_mem [MEM_WORDS];

    wstate_t     r_wstate;
    wstate_t     w_wnext;
    logic [3:0]  r_wcnt;
    logic        r_aw_got;
    logic        r_w_got;
    logic [29:0] r_awaddr;
    logic [31:0] r_wdata;
    logic        r_wlast;
    logic [1:0]  r_bresp;
    logic        w_commit;
    logic        w_werr;
    logic [29:0] w_waddr;
    logic [31:0] w_wdata;
    logic        w_wlast;

    rstate_t     r_rstate;
    rstate_t     w_rnext;
    logic [3:0]  r_rcnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        w_ar_hs;
    logic        w_rerr;

    logic        w_unused;
    assign w_unused = ^{i_awprot, i_arprot, i_awaddr[1:0], i_araddr[1:0]};

    // Address/data seen at commit: captured copy, or the beat completing now
    assign w_waddr = r_aw_got ? r_awaddr : i_awaddr[31:2];
    assign w_wdata = r_w_got ? r_wdata : i_wdata;
    assign w_wlast = r_w_got ? r_wlast : i_wlast;
    assign w_werr  = (w_waddr >= 30'(MEM_WORDS)) | ~w_wlast;
    assign w_rerr  = i_araddr[31:2] >= 30'(MEM_WORDS);

    assign o_bresp = r_bresp;
    assign o_rdata = r_rdata;
    assign o_rresp = r_rresp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wstate <= WIDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext   = r_wstate;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        w_commit  = 1'b0;
        unique case (r_wstate)
            WIDLE: begin
                if (i_awvalid | i_wvalid) begin
                    w_wnext = WWAIT;
                end
            end
            WWAIT: begin
                if (r_wcnt == 4'd0) begin
                    o_awready = i_awvalid & ~r_aw_got;
                    o_wready  = i_wvalid & ~r_w_got;
                    if ((r_aw_got | o_awready) & (r_w_got | o_wready)) begin
                        w_commit = 1'b1;
                        w_wnext  = WRESP;
                    end
                end
            end
            WRESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    w_wnext = WIDLE;
                end
            end
            default: w_wnext = WIDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wcnt   <= 4'd0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wlast  <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            if (r_wstate == WIDLE && w_wnext == WWAIT) begin
                r_wcnt <= 4'(WR_WAIT);
            end else if (r_wstate == WWAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_commit) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                r_bresp  <= w_werr ? 2'b10 : 2'b00;
            end else begin
                if (o_awready) begin
                    r_aw_got <= 1'b1;
                    r_awaddr <= i_awaddr[31:2];
                end
                if (o_wready) begin
                    r_w_got <= 1'b1;
                    r_wdata <= i_wdata;
                    r_wlast <= i_wlast;
                end
            end
        end
    end

    // Memory contents survive reset; only a committed, legal write lands
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit && !w_werr) begin
            r_mem[w_waddr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rstate <= RIDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        o_arready = 1'b0;
        o_rvalid  = 1'b0;
        w_ar_hs   = 1'b0;
        unique case (r_rstate)
            RIDLE: begin
                if (i_arvalid) begin
                    w_rnext = RWAIT;
                end
            end
            RWAIT: begin
                if (r_rcnt == 4'd0 && i_arvalid) begin
                    o_arready = 1'b1;
                    w_ar_hs   = 1'b1;
                    w_rnext   = RDATA;
                end
            end
            RDATA: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    w_rnext = RIDLE;
                end
            end
            default: w_rnext = RIDLE;
        endcase
    end

    // Read samples the array before a same-edge write lands
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rcnt  <= 4'd0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else begin
            if (r_rstate == RIDLE && w_rnext == RWAIT) begin
                r_rcnt <= 4'(RD_WAIT);
            end else if (r_rstate == RWAIT && r_rcnt != 4'd0) begin
                r_rcnt <= r_rcnt - 4'd1;
            end
            if (w_ar_hs) begin
                r_rdata <= w_rerr ? 32'd0 : r_mem[i_araddr[AW+1:2]];
                r_rresp <= w_rerr ? 2'b10 : 2'b00;
            end
        end
    end

endmodule
